team_03_gpio_event_logger: RTL and testbench

- Sits between the team 03 design's GPIO output bus and the Wishbone-readable status logic inside the team 03 wrapper.
- Watches the 34-bit pin vector {GPIO[37:5], GPIO[0]} and timestamps every change. It queues each {timestamp, value} pair in a small FIFO for firmware or a bench to drain.
- This is the synthesizable counterpart of the bench's "print on GPIO change" monitor, so the same checks run on silicon and in simulation.

---
 rtl/team_03_pkg.sv | 12 +
 rtl/team_03_gpio_event_logger_sync_fifo.sv | 65 ++++++
 rtl/team_03_gpio_event_logger.sv | 96 +++++++++
 tb/tb_team_03_gpio_event_logger.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/team_03_pkg.sv
// Shared constants and types for the team 03 GPIO event logger.
// The event struct matches the default TS_W/GPIO_W build.
package team_03_pkg;
   localparam int           GPIO_W   = 34;
   localparam int           TS_W_DEF = 16;
   localparam logic [7:0]   DROP_MAX = 8'hFF;

   typedef struct packed {
      logic [TS_W_DEF-1:0] ts;
      logic [GPIO_W-1:0]   data;
   } event_t;
endpackage

// File: rtl/team_03_gpio_event_logger_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush, occupancy and full/empty.
// Clear wins over push/pop; a push into a full FIFO is accepted only alongside a real pop.
module team_03_sync_fifo #(
   parameter int W     = 50,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_ok, pop_ok;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push_ok) - LW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; dout is masked while empty so it never shows stale data.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/team_03_gpio_event_logger.sv
// Timestamps every change of the watched GPIO vector and queues {ts, value} events.
// Enable rising edge re-baselines prev and restarts ts without logging.
module team_03_gpio_event_logger
   import team_03_pkg::*;
#(
   parameter int WIDTH = GPIO_W,
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         gpio_in,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [WIDTH-1:0]         ev_data,
   output logic [TS_W-1:0]          ev_ts,
   output logic [$clog2(DEPTH):0]   ev_level,
   output logic [7:0]               drop_count,
   output logic                     overflow
);
   logic             en_d_q, en_d_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic [7:0]       drop_q, drop_d;
   logic             ovf_q, ovf_d;
   logic             push;
   logic             fifo_full, fifo_empty;

   always_comb begin
      en_d_d = en;
      prev_d = prev_q;
      ts_d   = ts_q;
      push   = 1'b0;
      if (en && !en_d_q) begin
         prev_d = gpio_in;
         ts_d   = '0;
      end else if (en && en_d_q) begin
         ts_d = ts_q + TS_W'(1);
         if (gpio_in != prev_q) begin
            push   = 1'b1;
            prev_d = gpio_in;
         end
      end
   end

   // A full FIFO always has a head, so a ready consumer guarantees room for the push.
   always_comb begin
      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (clear) begin
         drop_d = '0;
         ovf_d  = 1'b0;
      end else if (push && fifo_full && !ev_ready) begin
         if (drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_d_q <= 1'b0;
         prev_q <= '0;
         ts_q   <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         en_d_q <= en_d_d;
         prev_q <= prev_d;
         ts_q   <= ts_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   team_03_sync_fifo #(
      .W     (TS_W + WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .din   ({ts_q, gpio_in}),
      .pop   (ev_ready),
      .dout  ({ev_ts, ev_data}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (ev_level)
   );

   assign ev_valid   = !fifo_empty;
   assign drop_count = drop_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_team_03_gpio_event_logger.sv
module tb_team_03_gpio_event_logger;
   import team_03_pkg::*;

   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst, en, clear, ev_ready;
   logic [33:0]   gpio_in;
   logic          ev_valid;
   logic [33:0]   ev_data;
   logic [15:0]   ev_ts;
   logic [3:0]    ev_level;
   logic [7:0]    drop_count;
   logic          overflow;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   event_t      mq[$];
   logic        m_en_d;
   logic [33:0] m_prev;
   logic [15:0] m_ts;
   int          m_drops;
   logic        m_ovf;

   always #12 clk = ~clk;

   team_03_gpio_event_logger dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clear      (clear),
      .gpio_in    (gpio_in),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_data    (ev_data),
      .ev_ts      (ev_ts),
      .ev_level   (ev_level),
      .drop_count (drop_count),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit     chg;
      bit     popv;
      event_t e;
      if (rst) begin
         mq.delete();
         m_en_d = 0; m_prev = '0; m_ts = '0; m_drops = 0; m_ovf = 0;
         return;
      end
      chg = 0;
      e.ts   = m_ts;
      e.data = gpio_in;
      if (en && !m_en_d) begin
         m_prev = gpio_in;
         m_ts   = '0;
      end else if (en && m_en_d) begin
         chg  = (gpio_in != m_prev);
         m_prev = gpio_in;
         m_ts = m_ts + 16'd1;
      end
      m_en_d = en;
      if (clear) begin
         mq.delete();
         m_drops = 0;
         m_ovf   = 0;
      end else begin
         popv = ev_ready && (mq.size() > 0);
         if (popv) void'(mq.pop_front());
         if (chg) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else begin
               if (m_drops < 255) m_drops++;
               m_ovf = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("ev_valid", 64'(ev_valid), 64'(mq.size() > 0));
      check("ev_level", 64'(ev_level), 64'(mq.size()));
      check("ev_data",  64'(ev_data),  (mq.size() > 0) ? 64'(mq[0].data) : 64'd0);
      check("ev_ts",    64'(ev_ts),    (mq.size() > 0) ? 64'(mq[0].ts)   : 64'd0);
      check("drop_count", 64'(drop_count), 64'(m_drops));
      check("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   task automatic step(input logic r, input logic e, input logic c, input logic rdy,
                       input logic [33:0] g);
      rst = r; en = e; clear = c; ev_ready = rdy; gpio_in = g;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      logic [33:0] g;
      rst = 1; en = 0; clear = 0; ev_ready = 0; gpio_in = '0;
      mq.delete();
      m_en_d = 0; m_prev = '0; m_ts = '0; m_drops = 0; m_ovf = 0;

      // reset
      step(1, 1, 0, 1, 34'h155);
      step(1, 1, 1, 1, 34'h2AA);
      check("rst_valid", 64'(ev_valid), 64'd0);
      check("rst_level", 64'(ev_level), 64'd0);
      check("rst_ovf",   64'(overflow), 64'd0);

      // idle enabled, no change
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 34'h0);
      check("idle_valid", 64'(ev_valid), 64'd0);
      check("idle_level", 64'(ev_level), 64'd0);
      check("idle_drops", 64'(drop_count), 64'd0);

      // single event ts=3
      step(0, 0, 0, 0, 34'h0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 34'h1);
      check("single_pre_level", 64'(ev_level), 64'd0);
      step(0, 1, 0, 0, 34'h3);
      check("single_valid", 64'(ev_valid), 64'd1);
      check("single_data",  64'(ev_data),  64'h3);
      check("single_ts",    64'(ev_ts),    64'd3);
      check("single_level", 64'(ev_level), 64'd1);
      step(0, 1, 0, 1, 34'h3);

      // ten changes into an 8-deep FIFO
      step(0, 0, 0, 0, 34'h0);
      step(0, 1, 0, 0, 34'h0);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 34'(i + 1));
      check("ovf_level", 64'(ev_level), 64'd8);
      check("ovf_drops", 64'(drop_count), 64'd2);
      check("ovf_flag",  64'(overflow), 64'd1);
      for (int i = 0; i < 8; i++) begin
         check("drain_ts", 64'(ev_ts), 64'(i));
         step(0, 1, 0, 1, 34'd10);
      end

      // full + push + pop
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 34'h100 + 34'(i));
      check("full_level", 64'(ev_level), 64'd8);
      step(0, 1, 0, 1, 34'h1FF);
      check("pp_level", 64'(ev_level), 64'd8);
      check("pp_drops", 64'(drop_count), 64'd2);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("pp_last", 64'(ev_data), 64'h1FF);
         step(0, 1, 0, 1, 34'h1FF);
      end

      // clear with a simultaneous change
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 34'h200 + 34'(i));
      check("clr_pre_level", 64'(ev_level), 64'd5);
      step(0, 1, 1, 0, 34'h300);
      check("clr_level", 64'(ev_level), 64'd0);
      check("clr_drops", 64'(drop_count), 64'd0);
      check("clr_ovf",   64'(overflow), 64'd0);
      step(0, 1, 0, 0, 34'h300);
      check("clr_lost", 64'(ev_level), 64'd0);

      // disabled change absorbed, ts restarts
      step(0, 0, 0, 0, 34'h2AA);
      step(0, 0, 0, 0, 34'h2AA);
      step(0, 1, 0, 0, 34'h2AA);
      step(0, 1, 0, 0, 34'h2AA);
      step(0, 1, 0, 0, 34'h2AA);
      check("reen_level", 64'(ev_level), 64'd0);
      step(0, 1, 0, 0, 34'h2AB);
      check("reen_ts",   64'(ev_ts),   64'd2);
      check("reen_data", 64'(ev_data), 64'h2AB);

      // randomized traffic
      g = 34'h2AB;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 0) g = g ^ (34'd1 << $urandom_range(0, 33));
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) == 0),
              g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
